// File: rtl/tof_arb_pkg.sv
// Shared types for the time-of-flight sample write arbiter.
package tof_arb_pkg;

    localparam int NUM_TOF = 8;

    typedef logic [2:0] tof_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/tof_write_arbiter_rr_pick.sv
// Round-robin search: first requesting channel above last_grant, wrapping,
// with last_grant itself checked last.
module rr_pick
    import tof_arb_pkg::*;
(
    input  logic [NUM_TOF-1:0] req,
    input  tof_idx_t           last_grant,
    output tof_idx_t           grant,
    output logic               valid
);

    tof_idx_t idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
        // Walk from farthest to nearest so the nearest requester is written last and wins.
        for (int k = NUM_TOF; k >= 1; k--) begin
            idx = last_grant + tof_idx_t'(k);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/tof_write_arbiter.sv
// Arbitrates eight ToF sensor data-ready requests onto one sample memory.
// Build with TOF_ARB_OVERRUN_EN defined to get sticky per-channel overrun flags.
module tof_write_arbiter
    import tof_arb_pkg::*;
#(
    parameter int SLOT_W       = 4,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_TOF-1:0]  tof_dr,
    input  logic                overrun_clr,
    output logic [2:0]          tof_sel,
    output logic                mem_we,
    output logic [SLOT_W+2:0]   mem_addr,
    output logic [NUM_TOF-1:0]  tof_ack,
    output logic                busy,
    output logic [NUM_TOF-1:0]  overrun
);

    localparam logic [3:0] WCNT_LAST = 4'(WRITE_CYCLES - 1);

    arb_state_t          state, next_state;
    logic [NUM_TOF-1:0]  dr_q;
    logic [NUM_TOF-1:0]  pending;
    logic [NUM_TOF-1:0]  rise;
    logic [SLOT_W-1:0]   slot [NUM_TOF];
    tof_idx_t            last_grant;
    logic [3:0]          wcnt;
    logic                load_sel;
    tof_idx_t            pick_grant;
    logic                pick_valid;

    assign rise     = tof_dr & ~dr_q;
    assign mem_addr = {tof_sel, slot[tof_sel]};

    rr_pick u_rr_pick (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        next_state = state;
        load_sel   = 1'b0;
        mem_we     = 1'b0;
        tof_ack    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = WRITE;
                    load_sel   = 1'b1;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                if (wcnt == WCNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                tof_ack[tof_sel] = 1'b1;
                next_state       = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dr_q       <= '0;
            pending    <= '0;
            last_grant <= tof_idx_t'(NUM_TOF - 1);
            tof_sel    <= '0;
            wcnt       <= '0;
            // NOTE: the slot counters are a tiny register array, not RAM, so resetting them is cheap and required.
            for (int i = 0; i < NUM_TOF; i++) begin
                slot[i] <= '0;
            end
        end else begin
            state   <= next_state;
            dr_q    <= tof_dr;
            // A fresh edge in the clearing cycle re-arms the channel.
            pending <= (pending & ~tof_ack) | rise;
            wcnt    <= (state == WRITE) ? wcnt + 4'd1 : 4'd0;
            if (load_sel) begin
                tof_sel <= pick_grant;
            end
            if (state == DONE) begin
                slot[tof_sel] <= slot[tof_sel] + 1'b1;
                last_grant    <= tof_sel;
            end
        end
    end

`ifdef TOF_ARB_OVERRUN_EN
    logic [NUM_TOF-1:0] overrun_q;
    logic [NUM_TOF-1:0] overrun_set;

    assign overrun_set = rise & pending & ~tof_ack;
    assign overrun     = overrun_q;

    // A new lost sample wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (overrun_clr) begin
            overrun_q <= overrun_set;
        end else begin
            overrun_q <= overrun_q | overrun_set;
        end
    end
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = overrun_clr;
    assign overrun            = '0;
`endif

endmodule

// File: tb/tb_tof_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_tof_write_arbiter;
    import tof_arb_pkg::*;

    localparam int SLOT_W = 4;
    localparam int WC     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        tof_dr;
    logic              overrun_clr;
    logic [2:0]        tof_sel;
    logic              mem_we;
    logic [SLOT_W+2:0] mem_addr;
    logic [7:0]        tof_ack;
    logic              busy;
    logic [7:0]        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_t = -1 idle, 0..WC-1 write beat, WC = completion cycle.
    logic [7:0] m_dr_prev, m_pend, m_over;
    int         m_slot [8];
    int         m_last, m_sel, m_t;

    int   ack_log [$];
    int   addr_log [$];
    logic prev_we;

    always #5 clk = ~clk;

    tof_write_arbiter #(.SLOT_W(SLOT_W), .WRITE_CYCLES(WC)) dut (
        .clk         (clk),
        .reset       (reset),
        .tof_dr      (tof_dr),
        .overrun_clr (overrun_clr),
        .tof_sel     (tof_sel),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .tof_ack     (tof_ack),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] rise, clr, set_ov;
        if (reset) begin
            m_dr_prev = '0;
            m_pend    = '0;
            m_over    = '0;
            for (int i = 0; i < 8; i++) m_slot[i] = 0;
            m_last = 7;
            m_sel  = 0;
            m_t    = -1;
        end else begin
            rise   = tof_dr & ~m_dr_prev;
            clr    = (m_t == WC) ? 8'(1 << m_sel) : 8'h00;
            set_ov = rise & m_pend & ~clr;
            if (m_t == WC) begin
                m_slot[m_sel] = (m_slot[m_sel] + 1) % (1 << SLOT_W);
                m_last        = m_sel;
                m_t           = -1;
            end else if (m_t >= 0) begin
                m_t++;
            end else if (m_pend != 0) begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_pend[(m_last + k) % 8]) begin
                        m_sel = (m_last + k) % 8;
                        break;
                    end
                end
                m_t = 0;
            end
            m_pend = (m_pend & ~clr) | rise;
`ifdef TOF_ARB_OVERRUN_EN
            m_over = overrun_clr ? set_ov : (m_over | set_ov);
`else
            m_over = set_ov & 8'h00;
`endif
            m_dr_prev = tof_dr;
        end
    endtask

    task automatic compare_outputs();
        logic [7:0] exp_ack;
        int         exp_addr;
        exp_ack  = (m_t == WC) ? 8'(1 << m_sel) : 8'h00;
        exp_addr = (m_sel << SLOT_W) | m_slot[m_sel];
        check("busy",     32'(busy),     32'(m_t >= 0));
        check("mem_we",   32'(mem_we),   32'(m_t >= 0 && m_t < WC));
        check("tof_ack",  32'(tof_ack),  32'(exp_ack));
        check("tof_sel",  32'(tof_sel),  32'(m_sel));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("overrun",  32'(overrun),  32'(m_over));
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_outputs();
            if (tof_ack != 0) ack_log.push_back($clog2(tof_ack));
            if (mem_we && !prev_we) addr_log.push_back(int'(mem_addr));
            prev_we = mem_we;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        tof_dr = '0;
        tick(2);
        reset  = 1'b0;
        ack_log.delete();
        addr_log.delete();
    endtask

    initial begin
        reset       = 1'b1;
        tof_dr      = '0;
        overrun_clr = 1'b0;
        prev_we     = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_busy",    32'(busy),    32'h0);
        check("reset_we",      32'(mem_we),  32'h0);
        check("reset_sel",     32'(tof_sel), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        // Single request on channel 3
        tof_dr = 8'h08;
        tick(1);
        check("single_lat_lo", 32'(mem_we), 32'h0);
        tick(1);
        check("single_we",   32'(mem_we),   32'h1);
        check("single_addr", 32'(mem_addr), 32'h30);
        tick(6);
        tof_dr = 8'h00;
        check("single_acks", 32'(ack_log.size()), 32'd1);
        if (ack_log.size() > 0) check("single_ack_ch", 32'(ack_log[0]), 32'd3);
        tick(1);
        tof_dr = 8'h08;
        tick(8);
        tof_dr = 8'h00;
        check("single_n_wr", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() > 1) check("single_slot1", 32'(addr_log[1]), 32'h31);
        tick(2);

        // All eight channels at once
        do_reset();
        tof_dr = 8'hFF;
        tick(40);
        tof_dr = 8'h00;
        check("simul_acks", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
            check("simul_order", 32'(ack_log[i]), 32'(i));
            check("simul_addr",  32'(addr_log[i]), 32'(i << SLOT_W));
        end
        check("simul_overrun", 32'(overrun), 32'h0);
        tick(2);

        // Fairness between channels 0 and 5
        do_reset();
        tof_dr = 8'h21;
        for (int c = 0; c < 24; c++) begin
            tick(1);
            tof_dr = (tof_dr | 8'h21) & ~tof_ack;
        end
        tof_dr = 8'h00;
        check("fair_n", 32'(ack_log.size() >= 4), 32'h1);
        if (ack_log.size() >= 4) begin
            check("fair_g0", 32'(ack_log[0]), 32'd0);
            check("fair_g1", 32'(ack_log[1]), 32'd5);
            check("fair_g2", 32'(ack_log[2]), 32'd0);
            check("fair_g3", 32'(ack_log[3]), 32'd5);
        end
        tick(10);

        // Slot counter wrap on channel 2
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tof_dr = 8'h04;
            tick(1);
            tof_dr = 8'h00;
            tick(5);
        end
        check("wrap_n", 32'(addr_log.size()), 32'd17);
        for (int i = 0; i < 17 && i < addr_log.size(); i++) begin
            check("wrap_addr", 32'(addr_log[i]), 32'(8'h20 + (i % 16)));
        end

        // Second edge on channel 4 while still pending
        do_reset();
        tof_dr = 8'h10;
        tick(1);
        tof_dr = 8'h00;
        tick(1);
        tof_dr = 8'h10;
        tick(8);
        tof_dr = 8'h00;
`ifdef TOF_ARB_OVERRUN_EN
        check("ovr_flag", 32'(overrun), 32'h10);
`else
        check("ovr_flag", 32'(overrun), 32'h00);
`endif
        check("ovr_one_write", 32'(ack_log.size()), 32'd1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h00);
        tick(2);

        // Reset during a write on channel 6
        do_reset();
        tof_dr = 8'h40;
        tick(2);
        check("rst_mid_we", 32'(mem_we), 32'h1);
        reset  = 1'b1;
        tof_dr = 8'h00;
        tick(1);
        check("rst_we_drop", 32'(mem_we),  32'h0);
        check("rst_no_ack",  32'(tof_ack), 32'h0);
        reset = 1'b0;
        tick(2);
        check("rst_ack_log", 32'(ack_log.size()), 32'd0);
        tof_dr = 8'h41;
        tick(12);
        tof_dr = 8'h00;
        check("rst_after_n", 32'(ack_log.size() >= 1), 32'h1);
        if (ack_log.size() >= 1) check("rst_after_ch0", 32'(ack_log[0]), 32'd0);
        tick(10);

        // Random traffic checked cycle by cycle against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [7:0] flip;
            flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
            tof_dr      = tof_dr ^ flip;
            overrun_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            tick(1);
            reset = 1'b0;
        end
        overrun_clr = 1'b0;
        tof_dr      = 8'h00;
        tick(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
